// File: rtl/div113_pkg.sv
// Shared constants and FSM state type for the divide-by-113 scheduler.
package div113_pkg;

   localparam int DIV113_X_W = 60;   // dividend width
   localparam int DIV113_Q_W = 54;   // quotient width, floor((2^60-1)/113) < 2^54
   localparam int DIV113_R_W = 7;    // remainder width, 0..112
   localparam int DIV113_D   = 113;  // constant divisor

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage : div113_pkg

// File: rtl/div113_rr_arb.sv
// Round-robin priority picker: first valid requester at or above i_ptr,
// wrapping past N_REQ-1 back to 0. Purely combinational.
module div113_rr_arb #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_idx
);

   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_pos;
   logic            w_found;

   // Scan N_REQ positions starting at i_ptr; keep the first hit only.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path can
      // leave it unassigned, which would otherwise infer a latch.
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
         end
         w_pos = w_sum[ID_W-1:0];
         if (!w_found && i_valid[w_pos]) begin
            w_found        = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule : div113_rr_arb

// File: rtl/div113_rr_sched.sv
// Round-robin scheduler sharing one combinational x/113, x%113 datapath
// among N_REQ requesters. Operand register -> divider -> result register,
// returned on a single tagged valid/ready response channel.
// Optional feature macro: DIV113_SELFCHECK_EN (reconstructs q*113+r and
// flags mismatches on rsp_err).
module div113_rr_sched
   import div113_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [DIV113_X_W*N_REQ-1:0] req_x,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [DIV113_Q_W-1:0]       rsp_q,
   output logic [DIV113_R_W-1:0]       rsp_r,
   output logic                        rsp_err
);

   state_t                r_state;
   state_t                w_next_state;
   logic [ID_W-1:0]       r_ptr;
   logic [ID_W-1:0]       r_id;
   logic [DIV113_X_W-1:0] r_x;
   logic [ID_W-1:0]       r_rsp_id;
   logic [DIV113_Q_W-1:0] r_rsp_q;
   logic [DIV113_R_W-1:0] r_rsp_r;

   logic [N_REQ-1:0]      w_grant;
   logic [ID_W-1:0]       w_idx;
   logic                  w_accept;
   logic [DIV113_X_W-1:0] w_win_x;
   logic [DIV113_Q_W-1:0] w_q;
   logic [DIV113_R_W-1:0] w_r;

   div113_rr_arb #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign w_win_x = req_x[DIV113_X_W*w_idx +: DIV113_X_W];

   // Constant divider: a full cycle between r_x and the result registers.
   assign w_q = DIV113_Q_W'(r_x / DIV113_X_W'(DIV113_D));
   assign w_r = DIV113_R_W'(r_x % DIV113_X_W'(DIV113_D));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next state and request-side handshake; ready depends only on state,
   // req_valid and r_ptr, never on rsp_ready.
   always_comb begin
      w_next_state = r_state;
      req_ready    = '0;
      w_accept     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (!rst) req_ready = w_grant;
            if (|w_grant) begin
               w_accept     = 1'b1;
               w_next_state = ST_EVAL;
            end
         end
         ST_EVAL: w_next_state = ST_RESP;
         ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand capture and round-robin pointer advance on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x   <= '0;
         r_id  <= '0;
         r_ptr <= '0;
      end else if (w_accept) begin
         r_x   <= w_win_x;
         r_id  <= w_idx;
         r_ptr <= (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + ID_W'(1);
      end
   end

   // Result capture at the end of EVAL; held through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_q  <= '0;
         r_rsp_r  <= '0;
         r_rsp_id <= '0;
      end else if (r_state == ST_EVAL) begin
         r_rsp_q  <= w_q;
         r_rsp_r  <= w_r;
         r_rsp_id <= r_id;
      end
   end

   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_q     = r_rsp_q;
   assign rsp_r     = r_rsp_r;

`ifdef DIV113_SELFCHECK_EN
   logic [DIV113_X_W-1:0] w_recon;
   logic                  w_mismatch;
   logic                  r_err;

   assign w_recon    = DIV113_X_W'(w_q) * DIV113_X_W'(DIV113_D) + DIV113_X_W'(w_r);
   assign w_mismatch = (w_recon != r_x) || (w_r >= DIV113_R_W'(DIV113_D));

   // Per-response error flag, registered alongside the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_err <= 1'b0;
      else if (r_state == ST_EVAL) r_err <= w_mismatch;
   end

   assign rsp_err = r_err;

   a_selfcheck : assert property (@(posedge clk) disable iff (rst)
      (r_state == ST_EVAL) |-> !w_mismatch);
`else
   assign rsp_err = 1'b0;
`endif

endmodule : div113_rr_sched

// File: tb/tb_div113_rr_sched.sv
// Scoreboard bench for div113_rr_sched: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_div113_rr_sched;

   localparam int N = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [60*N-1:0] req_x;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [53:0]   rsp_q;
   logic [6:0]    rsp_r;
   logic          rsp_err;

   typedef struct {
      logic [1:0]  id;
      logic [59:0] x;
      logic [53:0] q;
      logic [6:0]  r;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   div113_rr_sched #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q),
      .rsp_r     (rsp_r),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Monitor: every response handshake pops one expectation.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            logic [63:0] recon;
            e = sb.pop_front();
            recon = 64'(rsp_q) * 64'd113 + 64'(rsp_r);
            check("rsp_id",    64'(rsp_id),  64'(e.id));
            check("rsp_q",     64'(rsp_q),   64'(e.q));
            check("rsp_r",     64'(rsp_r),   64'(e.r));
            check("rsp_recon", recon,        64'(e.x));
            check("rsp_err",   64'(rsp_err), 64'd0);
         end
      end
   end

   // Present one operand on requester id, wait for its grant, accept.
   // Returns #1 after the acceptance edge.
   task automatic accept(input int id, input logic [59:0] x,
                         input logic [53:0] q, input logic [6:0] r,
                         input bit push);
      bit got;
      exp_t e;
      got = 1'b0;
      req_x[60*id +: 60] = x;
      req_valid[id] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("accept_timeout", 64'd0, 64'd1);
      e.id = 2'(id); e.x = x; e.q = q; e.r = r;
      if (got && push) sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
      check("drain_pending", 64'(sb.size()), 64'd0);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_id"},    64'(rsp_id),    64'd0);
      check({tag, "_q"},     64'(rsp_q),     64'd0);
      check({tag, "_r"},     64'(rsp_r),     64'd0);
      check({tag, "_err"},   64'(rsp_err),   64'd0);
   endtask

   // Round-robin operand table (hand computed).
   logic [59:0] rr_x [4] = '{60'd12345, 60'd113, 60'd112, 60'd1000};
   logic [53:0] rr_q [4] = '{54'd109,   54'd1,   54'd0,   54'd8};
   logic [6:0]  rr_r [4] = '{7'd28,     7'd0,    7'd112,  7'd96};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   rr_seq [5] = '{0, 1, 2, 3, 0};
      bit   got;
      exp_t e;

      rst       = 1'b1;
      req_valid = '0;
      req_x     = '0;
      rsp_ready = 1'b1;

      // Reset state; req_ready stays low while rst is high even with requests.
      repeat (2) @(posedge clk);
      #1 req_valid = 4'hF;
      @(negedge clk);
      check_zero_outputs("reset");
      check("reset_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 req_valid = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Single requester, latency: valid low in EVAL, high one cycle later.
      accept(0, 60'd12345, 54'd109, 7'd28, 1'b1);
      @(negedge clk);
      check("lat_eval_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("lat_resp_valid", 64'(rsp_valid), 64'd1);
      drain();

      // Boundary operands.
      accept(1, 60'hFFF_FFFF_FFFF_FFFF, 54'd10202845173511920, 7'd15, 1'b1);
      drain();
      accept(2, 60'd112, 54'd0, 7'd112, 1'b1);
      drain();
      accept(3, 60'd113, 54'd1, 7'd0, 1'b1);
      drain();
      accept(0, 60'd0, 54'd0, 7'd0, 1'b1);
      drain();

      // All four valid continuously from reset: grants 0,1,2,3,0.
      rst = 1'b1;
      for (int i = 0; i < 4; i++) req_x[60*i +: 60] = rr_x[i];
      req_valid = 4'hF;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         got = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) check("rr_timeout", 64'd0, 64'd1);
         check("rr_grant", 64'(req_ready), 64'd1 << rr_seq[g]);
         e.id = 2'(rr_seq[g]); e.x = rr_x[rr_seq[g]];
         e.q  = rr_q[rr_seq[g]]; e.r = rr_r[rr_seq[g]];
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (g == 4) req_valid = '0;
         @(negedge clk);
         check("rr_pulse", 64'(req_ready), 64'd0);
      end
      drain();

      // Back-pressure: response held 5 cycles, no new acceptance meanwhile.
      rsp_ready = 1'b0;
      accept(3, 60'd1000, 54'd8, 7'd96, 1'b1);
      req_x[120 +: 60] = 60'd0;
      req_valid[2] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("stall_valid_timeout", 64'd0, 64'd1);
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_q",     64'(rsp_q),     64'd8);
         check("stall_r",     64'(rsp_r),     64'd96);
         check("stall_id",    64'(rsp_id),    64'd3);
         check("stall_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      accept(2, 60'd0, 54'd0, 7'd0, 1'b1);
      drain();

      // Reset during EVAL: transaction dropped, pointer back to 0.
      accept(1, 60'd12345, 54'd109, 7'd28, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("midrst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_post_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      req_x[60 +: 60]  = 60'd12345;
      req_x[180 +: 60] = 60'd1000;
      req_valid = 4'b1010;
      @(negedge clk);
      check("midrst_ptr_grant", 64'(req_ready), 64'b0010);
      e.id = 2'd1; e.x = 60'd12345; e.q = 54'd109; e.r = 7'd28;
      if (req_ready == 4'b0010) sb.push_back(e);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      accept(3, 60'd1000, 54'd8, 7'd96, 1'b1);
      accept(2, 60'd226, 54'd2, 7'd0, 1'b1);
      drain();

`ifdef DIV113_SELFCHECK_EN
      // Random operands; expectation from the bench's own arithmetic.
      for (int n = 0; n < 10000; n++) begin
         int          id;
         logic [63:0] xr;
         logic [59:0] x;
         id = int'($urandom_range(0, N-1));
         xr = {$urandom, $urandom};
         x  = xr[59:0];
         accept(id, x, 54'(x / 60'd113), 7'(x % 60'd113), 1'b1);
      end
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_div113_rr_sched
